// File: rtl/ffe_mac_datapath.sv
// Feed-forward equalizer MAC datapath.
// A DEPTH-entry tap line and coefficient bank feed one signed multiplier; the
// external controller steps rd_addr through the taps, products accumulate, and
// a store strobe rounds/saturates the running sum onto ffe_out while the
// accumulator restarts with the current product in the same edge.
module ffe_mac_datapath #(
  parameter  int DATA_W    = 8,
  parameter  int COEF_W    = 8,
  parameter  int DEPTH     = 4,
  parameter  int FRAC      = 6,
  parameter  int OUT_W     = 10,
  localparam int ADDR_SIZE = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int ACC_W     = DATA_W + COEF_W + ADDR_SIZE
) (
  input  logic                 ffe_clk,
  input  logic                 rst,
  input  logic [DATA_W-1:0]    data_in,
  input  logic                 shift_en,
  input  logic                 rd_en,
  input  logic [ADDR_SIZE-1:0] rd_addr,
  input  logic                 str_out_n_rst_add_reg,
  input  logic                 coef_wr_en,
  input  logic [ADDR_SIZE-1:0] coef_wr_addr,
  input  logic [COEF_W-1:0]    coef_wr_data,
  output logic [OUT_W-1:0]     ffe_out,
  output logic                 out_valid
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0]       CNT_FULL = CNT_W'(DEPTH);
  localparam logic [ADDR_SIZE:0]     DEPTH_A  = (ADDR_SIZE + 1)'(DEPTH);
  // Half an output LSB, added before the arithmetic shift (round half up).
  localparam logic signed [ACC_W:0]  RND_C    = (FRAC > 0) ? (ACC_W + 1)'(1 << (FRAC - 1)) : '0;
  localparam logic signed [ACC_W:0]  OUT_MAX  = (ACC_W + 1)'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W:0]  OUT_MIN  = ~OUT_MAX;

  logic signed [DATA_W-1:0] x_q    [DEPTH];
  logic signed [DATA_W-1:0] x_d    [DEPTH];
  logic signed [COEF_W-1:0] coef_q [DEPTH];
  logic signed [COEF_W-1:0] coef_d [DEPTH];
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [OUT_W-1:0]         out_q, out_d;
  logic                     valid_q, valid_d;

  logic signed [DATA_W-1:0] x_sel;
  logic signed [COEF_W-1:0] coef_sel;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W:0]    rnd_sum;
  logic signed [ACC_W:0]    rnd_shr;
  logic [OUT_W-1:0]         sat_val;

  // Operand select from registered (pre-shift) taps; out-of-range index gives zero.
  always_comb begin
    x_sel    = '0;
    coef_sel = '0;
    if ({1'b0, rd_addr} < DEPTH_A) begin
      x_sel    = x_q[rd_addr];
      coef_sel = coef_q[rd_addr];
    end
  end

  // Full-precision signed product, sign-extended to accumulator width.
  assign prod     = $signed({{COEF_W{x_sel[DATA_W-1]}}, x_sel}) *
                    $signed({{DATA_W{coef_sel[COEF_W-1]}}, coef_sel});
  assign prod_ext = {{ADDR_SIZE{prod[PROD_W-1]}}, prod};

  // One guard bit keeps the rounding add from wrapping at the accumulator extremes.
  assign rnd_sum  = $signed({acc_q[ACC_W-1], acc_q}) + RND_C;
  assign rnd_shr  = rnd_sum >>> FRAC;

  // Clamp the rounded sum into the output range.
  always_comb begin
    sat_val = rnd_shr[OUT_W-1:0];
    if (rnd_shr > OUT_MAX) begin
      sat_val = OUT_MAX[OUT_W-1:0];
    end else if (rnd_shr < OUT_MIN) begin
      sat_val = OUT_MIN[OUT_W-1:0];
    end
  end

  // Next-state for tap line, coefficient bank, accumulator, counter and output.
  always_comb begin
    x_d     = x_q;
    coef_d  = coef_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    valid_d = 1'b0;

    if (shift_en) begin
      x_d[0] = data_in;
      for (int k = 1; k < DEPTH; k++) begin
        x_d[k] = x_q[k-1];
      end
    end

    // Written value lands at the edge, so a same-cycle read still sees the old one.
    if (coef_wr_en && ({1'b0, coef_wr_addr} < DEPTH_A)) begin
      coef_d[coef_wr_addr] = coef_wr_data;
    end

    if (rd_en) begin
      if (str_out_n_rst_add_reg) begin
        out_d   = sat_val;
        // Only a sum built from a full set of products is announced.
        valid_d = (cnt_q == CNT_FULL);
        acc_d   = prod_ext;
        cnt_d   = CNT_W'(1);
      end else begin
        acc_d = acc_q + prod_ext;
        cnt_d = (cnt_q == CNT_FULL) ? CNT_FULL : cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers with synchronous active-low clear.
  always_ff @(posedge ffe_clk) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        x_q[k]    <= '0;
        coef_q[k] <= '0;
      end
      acc_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      x_q     <= x_d;
      coef_q  <= coef_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign ffe_out   = out_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_ffe_mac_datapath.sv
// Self-checking bench for ffe_mac_datapath with a behavioural integer model.
module tb_ffe_mac_datapath;

  localparam int DEPTH  = 4;
  localparam int FRAC   = 6;
  localparam int OUT_W  = 10;
  localparam int NO_INJ = -1000;

  logic       ffe_clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       shift_en;
  logic       rd_en;
  logic [1:0] rd_addr;
  logic       str;
  logic       coef_wr_en;
  logic [1:0] coef_wr_addr;
  logic [7:0] coef_wr_data;
  logic [9:0] ffe_out;
  logic       out_valid;

  ffe_mac_datapath dut (
    .ffe_clk               (ffe_clk),
    .rst                   (rst),
    .data_in               (data_in),
    .shift_en              (shift_en),
    .rd_en                 (rd_en),
    .rd_addr               (rd_addr),
    .str_out_n_rst_add_reg (str),
    .coef_wr_en            (coef_wr_en),
    .coef_wr_addr          (coef_wr_addr),
    .coef_wr_data          (coef_wr_data),
    .ffe_out               (ffe_out),
    .out_valid             (out_valid)
  );

  always #5 ffe_clk = ~ffe_clk;

  int checks = 0;
  int errors = 0;

  // Reference model state, plain integers.
  int mx [DEPTH];
  int mc [DEPTH];
  int macc, mcnt, mout;
  bit mvalid;

  int pulse_vals[$];
  int diverge;

  function automatic int sat_round(int a);
    int r;
    r = (a + (2 ** (FRAC - 1))) >>> FRAC;
    if (r > (2 ** (OUT_W - 1)) - 1) r = (2 ** (OUT_W - 1)) - 1;
    if (r < -(2 ** (OUT_W - 1)))    r = -(2 ** (OUT_W - 1));
    return r;
  endfunction

  // Advance model by one clock using the current inputs, then clock the DUT.
  task automatic cycle();
    int p;
    int a;
    a = int'(rd_addr);
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        mx[k] = 0;
        mc[k] = 0;
      end
      macc = 0; mcnt = 0; mout = 0; mvalid = 0;
    end else begin
      p = rd_en ? mc[a] * mx[a] : 0;
      mvalid = 0;
      if (rd_en) begin
        if (str) begin
          mout   = sat_round(macc);
          mvalid = (mcnt == DEPTH);
          macc   = p;
          mcnt   = 1;
        end else begin
          macc = macc + p;
          mcnt = (mcnt < DEPTH) ? mcnt + 1 : DEPTH;
        end
      end
      if (shift_en) begin
        for (int k = DEPTH - 1; k > 0; k--) mx[k] = mx[k-1];
        mx[0] = int'($signed(data_in));
      end
      if (coef_wr_en) mc[int'(coef_wr_addr)] = int'($signed(coef_wr_data));
    end
    @(posedge ffe_clk);
    #1;
  endtask

  task automatic idle_inputs();
    shift_en = 0; rd_en = 0; rd_addr = 0; str = 0;
    coef_wr_en = 0; coef_wr_addr = 0; coef_wr_data = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 0;
    cycle();
    cycle();
    rst = 1;
  endtask

  task automatic write_coefs(input int c0, input int c1, input int c2, input int c3);
    int c [DEPTH];
    c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
    idle_inputs();
    for (int i = 0; i < DEPTH; i++) begin
      coef_wr_en   = 1;
      coef_wr_addr = 2'(i);
      coef_wr_data = 8'(c[i]);
      cycle();
    end
    idle_inputs();
  endtask

  // Controller sequence 0(shift), 3(store), 2, 1 per frame; optional coef[2]
  // write during the first frame's address-2 read.
  task automatic run_frames(input int n, input int din, input int inject);
    pulse_vals.delete();
    diverge = 0;
    data_in = 8'(din);
    for (int f = 0; f < n; f++) begin
      for (int s = 0; s < 4; s++) begin
        shift_en     = (s == 0);
        rd_en        = 1;
        rd_addr      = 2'((4 - s) % 4);
        str          = (s == 1);
        coef_wr_en   = (f == 0) && (s == 2) && (inject != NO_INJ);
        coef_wr_addr = 2'd2;
        coef_wr_data = 8'(inject);
        cycle();
        if (ffe_out !== mout[9:0] || out_valid !== mvalid) diverge++;
        if (out_valid === 1'b1) pulse_vals.push_back(int'($signed(ffe_out)));
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (ffe_out !== 10'd0) begin
      errors++; $display("FAIL reset_out: got %0d want 0", ffe_out);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %0b want 0", out_valid);
    end
  endtask

  task automatic test_steady_40();
    do_reset();
    write_coefs(64, 64, 64, 64);
    run_frames(8, 10, NO_INJ);
    checks++;
    if (diverge !== 0) begin
      errors++; $display("FAIL steady_model: diverging cycles %0d want 0", diverge);
    end
    checks++;
    if (pulse_vals.size() !== 7) begin
      errors++; $display("FAIL steady_pulses: got %0d want 7", pulse_vals.size());
    end else begin
      for (int i = 3; i < 7; i++) begin
        checks++;
        if (pulse_vals[i] !== 40) begin
          errors++; $display("FAIL steady_value[%0d]: got %0d want 40", i, pulse_vals[i]);
        end
      end
    end
  endtask

  task automatic test_rounding();
    do_reset();
    write_coefs(32, 0, 0, 0);
    run_frames(4, 1, NO_INJ);
    checks++;
    if (pulse_vals.size() == 0 || pulse_vals[$] !== 1) begin
      errors++; $display("FAIL round_pos: got %0d want 1", pulse_vals.size() ? pulse_vals[$] : -9999);
    end
    run_frames(4, -1, NO_INJ);
    checks++;
    if (pulse_vals.size() == 0 || pulse_vals[$] !== 0) begin
      errors++; $display("FAIL round_neg_half: got %0d want 0", pulse_vals.size() ? pulse_vals[$] : -9999);
    end
    checks++;
    if (diverge !== 0) begin
      errors++; $display("FAIL round_model: diverging cycles %0d want 0", diverge);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    write_coefs(127, 127, 127, 127);
    run_frames(6, 127, NO_INJ);
    checks++;
    if (pulse_vals.size() == 0 || pulse_vals[$] !== 511) begin
      errors++; $display("FAIL sat_high: got %0d want 511", pulse_vals.size() ? pulse_vals[$] : -9999);
    end
    run_frames(6, -128, NO_INJ);
    checks++;
    if (pulse_vals.size() == 0 || pulse_vals[$] !== -512) begin
      errors++; $display("FAIL sat_low: got %0d want -512", pulse_vals.size() ? pulse_vals[$] : -9999);
    end
    checks++;
    if (diverge !== 0) begin
      errors++; $display("FAIL sat_model: diverging cycles %0d want 0", diverge);
    end
  endtask

  task automatic test_first_store();
    do_reset();
    write_coefs(10, 20, 30, 40);
    run_frames(1, 5, NO_INJ);
    checks++;
    if (pulse_vals.size() !== 0) begin
      errors++; $display("FAIL first_store_quiet: got %0d pulses want 0", pulse_vals.size());
    end
    run_frames(1, 5, NO_INJ);
    checks++;
    if (pulse_vals.size() !== 1) begin
      errors++; $display("FAIL second_store_pulse: got %0d pulses want 1", pulse_vals.size());
    end
  endtask

  task automatic test_coef_same_cycle();
    do_reset();
    write_coefs(64, 64, 64, 64);
    run_frames(6, 10, NO_INJ);
    run_frames(3, 10, 0);
    checks++;
    if (pulse_vals.size() !== 3) begin
      errors++; $display("FAIL coef_rw_pulses: got %0d want 3", pulse_vals.size());
    end else begin
      checks++;
      if (pulse_vals[1] !== 40) begin
        errors++; $display("FAIL coef_rw_old: got %0d want 40", pulse_vals[1]);
      end
      checks++;
      if (pulse_vals[2] !== 30) begin
        errors++; $display("FAIL coef_rw_new: got %0d want 30", pulse_vals[2]);
      end
    end
  endtask

  task automatic test_idle_hold();
    int held;
    do_reset();
    write_coefs(64, 64, 64, 64);
    run_frames(6, 10, NO_INJ);
    held = int'($signed(ffe_out));
    rd_en = 0; str = 1; shift_en = 1; data_in = 8'd99;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (out_valid !== 1'b0 || int'($signed(ffe_out)) !== 40) begin
        errors++; $display("FAIL idle_hold: got out %0d valid %0b want 40/0 (held %0d)",
                           $signed(ffe_out), out_valid, held);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_midframe();
    do_reset();
    write_coefs(64, 64, 64, 64);
    run_frames(6, 10, NO_INJ);
    data_in = 8'd10;
    shift_en = 1; rd_en = 1; rd_addr = 0; str = 0; cycle();
    shift_en = 0; rd_addr = 3; str = 1; cycle();
    rd_addr = 2; str = 0; cycle();
    rst = 0; rd_addr = 1; str = 1; cycle();
    checks++;
    if (ffe_out !== 10'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL midframe_reset: got out %0d valid %0b want 0/0", ffe_out, out_valid);
    end
    rst = 1;
    idle_inputs();
    run_frames(1, 10, NO_INJ);
    checks++;
    if (pulse_vals.size() !== 0) begin
      errors++; $display("FAIL midframe_first_store: got %0d pulses want 0", pulse_vals.size());
    end
    run_frames(1, 10, NO_INJ);
    checks++;
    if (pulse_vals.size() !== 1) begin
      errors++; $display("FAIL midframe_full_frame: got %0d pulses want 1", pulse_vals.size());
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst          = ($urandom_range(0, 59) != 0);
      data_in      = 8'($urandom);
      shift_en     = ($urandom_range(0, 1) == 1);
      rd_en        = ($urandom_range(0, 9) < 7);
      rd_addr      = 2'($urandom);
      str          = ($urandom_range(0, 4) == 0);
      coef_wr_en   = ($urandom_range(0, 3) == 0);
      coef_wr_addr = 2'($urandom);
      coef_wr_data = 8'($urandom);
      cycle();
      checks++;
      if (ffe_out !== mout[9:0] || out_valid !== mvalid) begin
        errors++;
        if (bad < 5) $display("FAIL random[%0d]: got out %0d valid %0b want %0d/%0b",
                              i, $signed(ffe_out), out_valid, mout, mvalid);
        bad++;
      end
    end
    rst = 1;
    idle_inputs();
  endtask

  initial begin
    rst = 0;
    data_in = 0;
    idle_inputs();
    test_reset();
    test_steady_40();
    test_rounding();
    test_saturation();
    test_first_store();
    test_coef_same_cycle();
    test_idle_hold();
    test_reset_midframe();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ffe_mac_datapath.md
FFE_MAC_DATAPATH -- requirements
Module: ffe_mac_datapath

Interface
Parameters:
REQ-001 SHALL have DATA_W, default 8: signed input sample width.
REQ-002 SHALL have COEF_W, default 8: signed tap coefficient width.
REQ-003 SHALL have DEPTH, default 4: number of taps; ADDR_SIZE = $clog2(DEPTH).
REQ-004 SHALL have FRAC, default 6: coefficient fractional bits, removed at output.
REQ-005 SHALL have OUT_W, default 10: signed output width; ACC_W = DATA_W+COEF_W+ADDR_SIZE (18).

Ports:
REQ-006 SHALL have ffe_clk, input, 1: single clock; all state updates on its rising edge.
REQ-007 SHALL have rst, input, 1: reset, synchronous, active-low.
REQ-008 SHALL have data_in, input, DATA_W: signed sample.
REQ-009 SHALL have shift_en, input, 1: shift data_in into the tap line.
REQ-010 SHALL have rd_en, input, 1: accumulate the product for rd_addr this cycle.
REQ-011 SHALL have rd_addr, input, ADDR_SIZE: tap/coefficient index.
REQ-012 SHALL have str_out_n_rst_add_reg, input, 1: store sum to output and restart accumulator.
REQ-013 SHALL have coef_wr_en, input, 1: coefficient write strobe.
REQ-014 SHALL have coef_wr_addr, input, ADDR_SIZE: coefficient write index.
REQ-015 SHALL have coef_wr_data, input, COEF_W: signed coefficient value.
REQ-016 SHALL have ffe_out, output, OUT_W: registered, rounded, saturated filter output.
REQ-017 SHALL have out_valid, output, 1: one-cycle pulse when ffe_out carries a complete sum.

Function
REQ-018 Tap line x[0..DEPTH-1] SHALL update on shift_en: x[0]<=data_in, x[k]<=x[k-1]; it holds otherwise.
REQ-019 Coefficient bank coef[0..DEPTH-1] SHALL be written on coef_wr_en; a write is visible to reads from the next cycle.
REQ-020 A same-cycle read of the written address SHALL return the old value.
REQ-021 When rd_en=1, the product p = coef[rd_addr]*x[rd_addr] SHALL use pre-shift tap values, even when shift_en=1 in the same cycle.
REQ-022 The product SHALL be a full-precision signed product sign-extended to ACC_W; the accumulator SHALL never overflow for DEPTH products.
REQ-023 When rd_en=1 and str_out_n_rst_add_reg=0, the block SHALL set acc<=acc+p and cnt<=min(cnt+1,DEPTH).
REQ-024 When rd_en=1 and str_out_n_rst_add_reg=1, the block SHALL set ffe_out<=sat(round(acc)), acc<=p and cnt<=1 in the same edge.
REQ-025 In the REQ-024 case, out_valid SHALL be asserted the next cycle only if cnt==DEPTH before the edge.
REQ-026 When rd_en=0, acc, cnt and ffe_out SHALL hold, and str_out_n_rst_add_reg SHALL be ignored.
REQ-027 round(acc) SHALL equal (acc + 2^(FRAC-1)) >>> FRAC (arithmetic shift, round half up).
REQ-028 sat() SHALL clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1], i.e. [-512, 511].
REQ-029 out_valid SHALL be high for exactly one cycle per qualifying store; ffe_out SHALL hold between stores.
REQ-030 The normal controller sequence SHALL be: rd_addr 0 (shift_en=1), 3 (store), 2, 1, 0, ...
REQ-031 The first store after reset or idle SHALL not pulse out_valid unless DEPTH products were accumulated since the last store.
REQ-032 cnt SHALL saturate at DEPTH; extra products without a store SHALL still add to acc.
REQ-033 Behaviour for rd_addr >= DEPTH is undefined when DEPTH is not a power of two; the block SHALL then contribute product 0.

Reset
REQ-034 When rst=0 at a clock edge, the block SHALL clear x[], coef[], acc, cnt, ffe_out and out_valid to 0.
REQ-035 Reset SHALL override every other input, including mid-frame; the first store after reset SHALL not pulse out_valid.

Verification
REQ-036 Scenario: coef[0..3]=64, data_in=10 held, controller sequence running -> after taps fill, out_valid pulses once per 4 cycles with ffe_out=40.
REQ-037 Scenario: coef[0]=32, others 0, data_in=1 -> ffe_out=1; with data_in=-1 -> ffe_out=0 (round half up).
REQ-038 Scenario: all coef=127, data_in=127 -> ffe_out=511; all coef=127, data_in=-128 -> ffe_out=-512 (saturation).
REQ-039 Scenario: first frame after reset, where the store is reached with cnt=1 -> out_valid stays 0; the next store asserts out_valid.
REQ-040 Scenario: coef write to address 2 in the same cycle rd_addr=2 is read -> old coefficient is used; the next frame uses the new value.
REQ-041 Scenario: rst=0 asserted mid-frame with acc nonzero -> all outputs are 0 next cycle, and no out_valid occurs until a full frame completes.
